// File: rtl/fetch_buffer_unit_pkg.sv
// Shared types for the instruction fetch buffer.
//   fb_state_t    : fetch controller state (IDLE, FETCH)
//   fetch_entry_t : one queued fetch result {pc, instr} at the default widths;
//                   the queue packs entries in this same order (pc in the MSBs).
//   fb_cnt_w()    : width of an occupancy counter able to hold 0..depth
package fetch_buffer_unit_pkg;

   localparam int FB_PC_W    = 8;
   localparam int FB_INSTR_W = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fb_state_t;

   typedef struct packed {
      logic [FB_PC_W-1:0]    pc;
      logic [FB_INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic int fb_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_buffer_unit_fifo.sv
// Fetch queue: DEPTH-entry FIFO with first-word fall-through head.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   push, push_data     write tail (accepted when not full, or when popping)
//   pop                 remove head (ignored when empty)
//   flush               empty the queue; wins over push and pop
//   head_data           registered head entry (undefined when empty)
//   full, empty, count  occupancy
module fetch_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             head_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_en;
   logic             pop_en;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing reads it while count_q is zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_buffer_unit.sv
// Instruction fetch buffer: issues sequential reads to a one-cycle-latency
// instruction memory, queues {pc, instr} results and hands them to a
// valid/ready consumer. Redirects flush the queue and restart fetch.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   fetch_en                        allow new memory requests
//   redirect_valid, redirect_target flush and restart fetch at target
//   imem_req, imem_addr             memory read request / address
//   imem_rdata                      read data, one cycle after the request
//   out_valid, out_ready            head handshake
//   out_instr, out_pc               head entry (zero when the queue is empty)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | first cycle out of reset, no requests
// FETCH | issue requests whenever enabled and queue space is reserved
module fetch_buffer_unit
   import fetch_buffer_unit_pkg::*;
#(
   parameter int          PC_W     = 8,
   parameter int          INSTR_W  = 16,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_target,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
);

   localparam int              CNT_W      = fb_cnt_w(DEPTH);
   localparam int              ENT_W      = PC_W + INSTR_W;
   localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

   fb_state_t        state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             inflight_q, inflight_d;
   logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [ENT_W-1:0] head_entry;
   logic             room;

   // Space is reserved for the in-flight response so it can never be dropped.
   assign room = !fifo_full &&
                 (({1'b0, fifo_count} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH));

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      imem_req      = 1'b0;

      case (state_q)
         IDLE:    state_d  = FETCH;
         FETCH:   imem_req = fetch_en && !redirect_valid && room;
         default: state_d  = IDLE;
      endcase

      if (redirect_valid) begin
         pc_d = redirect_target;
      end else if (imem_req) begin
         pc_d = pc_q + PC_W'(1);
      end

      // A response already in flight during a redirect is killed because it
      // is never pushed; imem_req is low in that cycle so nothing new starts.
      inflight_d = imem_req;
      if (imem_req) begin
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC_V;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign fifo_push = inflight_q && !redirect_valid;
   assign fifo_pop  = out_valid && out_ready;

   fetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data ({inflight_pc_q, imem_rdata}),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign imem_addr = pc_q;
   assign out_valid = !fifo_empty;
   assign out_instr = fifo_empty ? '0 : head_entry[INSTR_W-1:0];
   assign out_pc    = fifo_empty ? '0 : head_entry[ENT_W-1:INSTR_W];

endmodule

// File: tb/tb_fetch_buffer_unit.sv
module tb_fetch_buffer_unit;
   import fetch_buffer_unit_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [7:0]  redirect_target;
   logic        out_ready;

   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [7:0]  out_pc;

   logic        fe_imem_req;
   logic [7:0]  fe_imem_addr;
   logic [15:0] fe_imem_rdata;
   logic        fe_out_valid;
   logic [15:0] fe_out_instr;
   logic [7:0]  fe_out_pc;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   fetch_entry_t exp_q[$];
   fetch_entry_t mon_e;
   logic [7:0]   fe_exp [4];

   fetch_buffer_unit #(.PC_W(8), .INSTR_W(16), .DEPTH(4), .RESET_PC(0)) u_dut (
      .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   fetch_buffer_unit #(.PC_W(8), .INSTR_W(16), .DEPTH(4), .RESET_PC(8'hFE)) u_dut_fe (
      .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(fe_imem_req), .imem_addr(fe_imem_addr), .imem_rdata(fe_imem_rdata),
      .out_valid(fe_out_valid), .out_ready(out_ready),
      .out_instr(fe_out_instr), .out_pc(fe_out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: data = addr + 0x1000 one cycle after a request, junk otherwise.
   always @(posedge clk) begin
      imem_rdata    <= imem_req    ? ({8'h00, imem_addr}    + 16'h1000) : 16'hDEAD;
      fe_imem_rdata <= fe_imem_req ? ({8'h00, fe_imem_addr} + 16'h1000) : 16'hDEAD;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %0h, want %0h", name, cyc, act, exp_v);
      end
   endtask

   task automatic exp_restart(input logic [7:0] pc0);
      fetch_entry_t e;
      logic [7:0]   p;
      exp_q.delete();
      p = pc0;
      for (int i = 0; i < 64; i++) begin
         e.pc    = p;
         e.instr = {8'h00, p} + 16'h1000;
         exp_q.push_back(e);
         p = p + 8'd1;
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) nxt();
   endtask

   // Scoreboard monitor: every head transfer must match the next expected entry.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_unexpected (cycle %0d): got pc %0h, want no transfer", cyc, out_pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_pc", {24'h0, out_pc}, {24'h0, mon_e.pc});
            chk("sb_instr", {16'h0, out_instr}, {16'h0, mon_e.instr});
         end
      end
   end

   initial begin
      fe_exp[0] = 8'hFE; fe_exp[1] = 8'hFF; fe_exp[2] = 8'h00; fe_exp[3] = 8'h01;
      reset_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b0; redirect_target = 8'h00;
      exp_restart(8'h00);
      nxt(); nxt();

      chk("rst_imem_req",  imem_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_out_pc",    out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_fe_addr",   fe_imem_addr, 32'hFE);

      // Release: cycle 0 is IDLE, first request in cycle 1, data at head in cycle 3.
      reset_n = 1'b1;
      cyc = 0;
      @(negedge clk); chk("idle_no_req", imem_req, 0);
      goto(1); @(negedge clk);
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 0);
      goto(2); @(negedge clk); chk("first_lat_valid", out_valid, 0);
      for (int c = 3; c <= 10; c++) begin
         goto(c); @(negedge clk);
         chk("thru_valid", out_valid, 1);
         chk("thru_pc", out_pc, c - 3);
         if (c <= 6) begin
            chk("fe_wrap_pc", fe_out_pc, fe_exp[c-3]);
            chk("fe_wrap_instr", fe_out_instr, {8'h00, fe_exp[c-3]} + 16'h1000);
         end
      end

      // Back-pressure: queue fills with pcs 8..11 and requests stop.
      goto(11); out_ready = 1'b0;
      goto(13); @(negedge clk); chk("stall_limit_req", imem_req, 0);
      goto(20); @(negedge clk);
      chk("full_valid", out_valid, 1);
      chk("full_head_pc", out_pc, 8'h08);
      chk("full_req", imem_req, 0);
      chk("full_addr", imem_addr, 8'h0C);
      goto(21); out_ready = 1'b1;
      @(negedge clk); chk("full_pop_no_req", imem_req, 0);
      goto(22); @(negedge clk);
      chk("refill_req", imem_req, 1);
      chk("refill_addr", imem_addr, 8'h0C);

      // Redirect with 3 queued (pcs 0x11..0x13) and pc 0x14 in flight.
      goto(30); out_ready = 1'b0;
      goto(31); out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h40;
      @(negedge clk);
      chk("redir_head_pc", out_pc, 8'h11);
      chk("redir_no_req", imem_req, 0);
      goto(32); redirect_valid = 1'b0; exp_restart(8'h40);
      @(negedge clk);
      chk("redir_flushed", out_valid, 0);
      chk("redir_req", imem_req, 1);
      chk("redir_addr", imem_addr, 8'h40);
      goto(33); @(negedge clk); chk("redir_lat_valid", out_valid, 0);
      goto(34); @(negedge clk);
      chk("redir_out_valid", out_valid, 1);
      chk("redir_out_pc", out_pc, 8'h40);
      chk("redir_out_instr", out_instr, 16'h1040);

      // Back-to-back redirects: only 0xC0 takes effect.
      goto(40); redirect_valid = 1'b1; redirect_target = 8'h80;
      @(negedge clk); chk("b2b_no_req0", imem_req, 0);
      goto(41); redirect_target = 8'hC0;
      @(negedge clk);
      chk("b2b_no_req1", imem_req, 0);
      chk("b2b_flushed", out_valid, 0);
      goto(42); redirect_valid = 1'b0; exp_restart(8'hC0);
      @(negedge clk);
      chk("b2b_req", imem_req, 1);
      chk("b2b_addr", imem_addr, 8'hC0);
      goto(44); @(negedge clk); chk("b2b_out_pc", out_pc, 8'hC0);

      // fetch_en low for one cycle with pc 0xC7 in flight.
      goto(50); fetch_en = 1'b0;
      @(negedge clk); chk("fen_off_req", imem_req, 0);
      goto(51); fetch_en = 1'b1;
      @(negedge clk);
      chk("fen_on_req", imem_req, 1);
      chk("fen_on_addr", imem_addr, 8'hC8);
      chk("fen_inflight_pc", out_pc, 8'hC7);
      goto(52); @(negedge clk); chk("fen_bubble", out_valid, 0);
      goto(53); @(negedge clk); chk("fen_resume_pc", out_pc, 8'hC8);

      // Longer fetch_en drop: queue drains, fetch resumes where it stopped.
      goto(55); fetch_en = 1'b0;
      goto(60); @(negedge clk);
      chk("drain_valid", out_valid, 0);
      chk("drain_req", imem_req, 0);
      chk("drain_addr", imem_addr, 8'hCC);
      goto(61); fetch_en = 1'b1;
      @(negedge clk); chk("drain_resume_addr", imem_addr, 8'hCC);
      goto(63); @(negedge clk); chk("drain_resume_pc", out_pc, 8'hCC);

      // Asynchronous reset pulse mid-burst, released within the same cycle.
      goto(70);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_imem_req", imem_req, 0);
      chk("arst_imem_addr", imem_addr, 0);
      chk("arst_out_pc", out_pc, 0);
      chk("arst_out_instr", out_instr, 0);
      chk("arst_fe_addr", fe_imem_addr, 32'hFE);
      exp_restart(8'h00);
      reset_n = 1'b1;
      @(negedge clk); chk("arst_idle_req", imem_req, 0);
      goto(71); @(negedge clk);
      chk("arst_stale_killed", out_valid, 0);
      chk("arst_req", imem_req, 1);
      chk("arst_addr", imem_addr, 0);
      goto(72); @(negedge clk); chk("arst_lat_valid", out_valid, 0);
      goto(73); @(negedge clk);
      chk("arst_out_pc", out_pc, 0);
      chk("arst_out_valid2", out_valid, 1);
      chk("arst_fe_pc", fe_out_pc, 8'hFE);

      goto(80);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_buffer_unit.md
FETCH_BUFFER_UNIT -- requirements
Module: fetch_buffer_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning program-counter width in bits.
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning instruction width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; legal values are powers of 2 and >= 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port fetch_en  input  1  permits issue of new memory requests.
REQ-008 The block SHALL have port redirect_valid  input  1  branch/flush request.
REQ-009 The block SHALL have port redirect_target  input  PC_W  new fetch address.
REQ-010 The block SHALL have port imem_req  output  1  memory read request this cycle.
REQ-011 The block SHALL have port imem_addr  output  PC_W  memory read address.
REQ-012 The block SHALL have port imem_rdata  input  INSTR_W  read data, valid exactly one cycle after the request.
REQ-013 The block SHALL have port out_valid  output  1  head entry available.
REQ-014 The block SHALL have port out_ready  input  1  consumer accepts head.
REQ-015 The block SHALL have port out_instr  output  INSTR_W  head instruction.
REQ-016 The block SHALL have port out_pc  output  PC_W  address of the head instruction.

Function
REQ-017 The FSM SHALL have states IDLE and FETCH; IDLE lasts exactly one cycle after reset_n deasserts, then the FSM moves to FETCH and never returns except via reset.
REQ-018 In FETCH, imem_req SHALL be 1 iff fetch_en=1, redirect_valid=0 and (queue count + in-flight requests) < DEPTH; imem_addr SHALL equal pc_q.
REQ-019 On every issued request, pc_q SHALL increment by 1 modulo 2^PC_W; 2^PC_W-1 wraps to 0.
REQ-020 The response for a request issued in cycle t SHALL be written to the queue tail at the end of cycle t+1 together with that request's address, unless it was killed.
REQ-021 out_valid SHALL equal queue-not-empty; out_instr and out_pc SHALL be driven from registered head storage, first-word fall-through.
REQ-022 A transfer SHALL occur when out_valid=1 and out_ready=1, popping the head.
REQ-023 Push and pop SHALL be allowed in the same cycle, including when the queue is full or empty.
REQ-024 The queue SHALL sustain 1 instruction per cycle when out_ready is held at 1 and fetch_en is held at 1.
REQ-025 When redirect_valid=1 in cycle t, the following SHALL occur at the end of cycle t:
  - the queue is emptied;
  - any in-flight response is killed;
  - pc_q is loaded with redirect_target.
REQ-026 No request SHALL be issued in the redirect cycle; the first request to the target SHALL be issued in cycle t+1, with out_valid for it no earlier than cycle t+3.
REQ-027 Redirect SHALL take priority over a simultaneous push; a simultaneous pop is treated as completed.
REQ-028 Back-to-back redirects SHALL each reload pc_q, and only the last one SHALL take effect.
REQ-029 When fetch_en=0, new requests SHALL stop, while in-flight responses SHALL still be captured and the queue SHALL still drain.
REQ-030 Queue pointers SHALL wrap modulo DEPTH, and count SHALL be $clog2(DEPTH+1) bits wide.

Reset
REQ-031 On reset_n=0, the following SHALL take effect immediately, independent of clk:
  - state=IDLE;
  - pc_q=RESET_PC;
  - queue empty, in-flight cleared;
  - out_valid=0, imem_req=0, imem_addr=RESET_PC;
  - out_instr=0, out_pc=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued and in-flight instructions, and the response arriving after reset SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, FETCH) and a fetch-entry struct {pc, instr}.
REQ-034 The queue SHALL be a sub-module fetch_fifo, parametrised by width and DEPTH, with push, pop, flush, full, empty and count.

Verification
REQ-035 Scenario: reset release, fetch_en=1, out_ready=1, memory returns addr+16'h1000 -> first request in cycle 2 at 0x00; out (pc=0x00, instr=0x1000) in cycle 4; one instruction per cycle thereafter.
REQ-036 Scenario: out_ready=0 for 10 cycles -> exactly 4 entries queued, imem_req=0 while full; out_ready=1 -> pcs 0,1,2,3 delivered in order with no loss.
REQ-037 Scenario: redirect_valid=1 with target 0x40 while 3 entries are queued and 1 is in flight -> out_valid=0 next cycle, request at 0x40 next cycle, out_pc=0x40 three cycles after the redirect, no stale pcs delivered.
REQ-038 Scenario: RESET_PC=0xFE, continuous fetch -> delivered pcs 0xFE, 0xFF, 0x00, 0x01.
REQ-039 Scenario: fetch_en dropped for 1 cycle while a request is in flight -> that response is still delivered, then no further requests until fetch_en returns.
REQ-040 Scenario: reset_n pulsed low asynchronously mid-burst -> outputs reach reset values before the next clk edge, and fetching restarts at RESET_PC.
